// File: rtl/rgb565_grayscale_stream.sv
// Streaming RGB565 -> grayscale converter, LANES pixels per beat, two-stage valid/ready pipeline.
// Define GRAYSCALE_ROUND_EN to round the luma to nearest instead of truncating.
`timescale 1ns/1ps

module rgb565_grayscale_stream #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned COEF_R = 54,
    parameter int unsigned COEF_G = 183,
    parameter int unsigned COEF_B = 19
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [16*LANES-1:0]   i_s_data,
    input  logic                  i_s_last,
    input  logic                  i_s_mode,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [16*LANES-1:0]   o_m_data,
    output logic                  o_m_last
);

    localparam logic [7:0] CoefR = COEF_R[7:0];
    localparam logic [7:0] CoefG = COEF_G[7:0];
    localparam logic [7:0] CoefB = COEF_B[7:0];

`ifdef GRAYSCALE_ROUND_EN
    localparam logic [16:0] RoundBias = 17'd128;
`else
    localparam logic [16:0] RoundBias = 17'd0;
`endif

    logic                w_en1;
    logic                w_en2;
    logic [15:0]         w_prod_r [LANES];
    logic [15:0]         w_prod_g [LANES];
    logic [15:0]         w_prod_b [LANES];
    logic [16*LANES-1:0] w_lane_out;

    logic                r_v1;
    logic                r_mode1;
    logic                r_last1;
    logic [15:0]         r_prod_r [LANES];
    logic [15:0]         r_prod_g [LANES];
    logic [15:0]         r_prod_b [LANES];
    logic                r_m_valid;
    logic [16*LANES-1:0] r_m_data;
    logic                r_m_last;

    // Stage 2 frees up when it is empty or being drained; stage 1 when empty or moving on.
    always_comb begin
        w_en2     = !r_m_valid || i_m_ready;
        w_en1     = !r_v1 || w_en2;
        o_s_ready = w_en1 && !i_reset;
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [4:0]  w_r;
        logic [5:0]  w_g;
        logic [4:0]  w_b;
        logic [7:0]  w_r8;
        logic [7:0]  w_g8;
        logic [7:0]  w_b8;
        logic [16:0] w_sum;
        logic [7:0]  w_y;

        assign {w_r, w_g, w_b} = i_s_data[16*gi +: 16];
        assign w_r8 = {w_r, w_r[4:2]};
        assign w_g8 = {w_g, w_g[5:4]};
        assign w_b8 = {w_b, w_b[4:2]};

        assign w_prod_r[gi] = {8'h00, CoefR} * {8'h00, w_r8};
        assign w_prod_g[gi] = {8'h00, CoefG} * {8'h00, w_g8};
        assign w_prod_b[gi] = {8'h00, CoefB} * {8'h00, w_b8};

        // Weights sum to at most 256, so the luma never exceeds 255 and needs no clamp.
        assign w_sum = {1'b0, r_prod_r[gi]} + {1'b0, r_prod_g[gi]} + {1'b0, r_prod_b[gi]}
                     + RoundBias;
        assign w_y   = 8'(w_sum >> 8);

        assign w_lane_out[16*gi +: 16] = r_mode1 ? {w_y[7:3], w_y[7:2], w_y[7:3]}
                                                 : {8'h00, w_y};
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_v1      <= 1'b0;
            r_mode1   <= 1'b0;
            r_last1   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_prod_r[i] <= '0;
                r_prod_g[i] <= '0;
                r_prod_b[i] <= '0;
            end
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else begin
            if (w_en1) begin
                r_v1 <= i_s_valid && o_s_ready;
                if (i_s_valid) begin
                    r_mode1 <= i_s_mode;
                    r_last1 <= i_s_last;
                    for (int i = 0; i < LANES; i++) begin
                        r_prod_r[i] <= w_prod_r[i];
                        r_prod_g[i] <= w_prod_g[i];
                        r_prod_b[i] <= w_prod_b[i];
                    end
                end
            end
            // Output data only changes when a real beat moves in, so an idle bus keeps its value.
            if (w_en2) begin
                r_m_valid <= r_v1;
                if (r_v1) begin
                    r_m_data <= w_lane_out;
                    r_m_last <= r_last1;
                end
            end
        end
    end

    assign o_m_valid = r_m_valid;
    assign o_m_data  = r_m_data;
    assign o_m_last  = r_m_last;

endmodule

// File: tb/tb_rgb565_grayscale_stream.sv
// Self-checking bench for rgb565_grayscale_stream: directed literals, burst, backpressure,
// mid-stream reset and a randomized scoreboard run against an arithmetic luma model.
`timescale 1ns/1ps

module tb_rgb565_grayscale_stream;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_mode;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;

    int n_checks = 0;
    int n_fail   = 0;

    rgb565_grayscale_stream #(
        .LANES  (2),
        .COEF_R (54),
        .COEF_G (183),
        .COEF_B (19)
    ) u_dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_s_valid (s_valid),
        .o_s_ready (s_ready),
        .i_s_data  (s_data),
        .i_s_last  (s_last),
        .i_s_mode  (s_mode),
        .o_m_valid (m_valid),
        .i_m_ready (m_ready),
        .o_m_data  (m_data),
        .o_m_last  (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Luma from the plain weighted-sum formula on bit-replicated 8-bit channels.
    function automatic logic [31:0] model_beat(input logic [31:0] d, input logic mode);
        logic [31:0] res;
        int p, r, g, b, r8, g8, b8, sum, y, lane;
        res = '0;
        for (int i = 0; i < 2; i++) begin
            p  = int'((d >> (16 * i)) & 32'h0000_FFFF);
            r  = p / 2048;
            g  = (p / 32) % 64;
            b  = p % 32;
            r8 = r * 8 + r / 4;
            g8 = g * 4 + g / 16;
            b8 = b * 8 + b / 4;
            sum = 54 * r8 + 183 * g8 + 19 * b8;
`ifdef GRAYSCALE_ROUND_EN
            sum = sum + 128;
`endif
            y    = sum / 256;
            lane = mode ? ((y / 8) * 2048 + (y / 4) * 32 + (y / 8)) : y;
            res  = res | (32'(lane) << (16 * i));
        end
        return res;
    endfunction

    // Scoreboard: every accepted beat must come out once, in order, with its own last/mode.
    logic [32:0] sb_q[$];
    logic [32:0] exp_beat;
    logic        hold;
    logic [31:0] hold_data;
    logic        hold_last;

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_data", m_data, hold_data);
                check("hold_last", 32'(m_last), 32'(hold_last));
            end
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got beat %h, expected none at %0t",
                             m_data, $time);
                end else begin
                    exp_beat = sb_q.pop_front();
                    check("sb_data", m_data, exp_beat[31:0]);
                    check("sb_last", 32'(m_last), 32'(exp_beat[32]));
                end
            end
            if (s_valid && s_ready) sb_q.push_back({s_last, model_beat(s_data, s_mode)});
            check("in_flight_le2", 32'(sb_q.size() > 2), 32'd0);
            hold      = m_valid && !m_ready;
            hold_data = m_data;
            hold_last = m_last;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single beat into an empty pipeline with m_ready high: output after exactly 2 cycles.
    task automatic run_single(input string name, input logic [31:0] d, input logic mode,
                              input logic [31:0] exp);
        s_valid = 1'b1;
        s_data  = d;
        s_mode  = mode;
        s_last  = 1'b1;
        @(negedge clk);
        check({name, "_s_ready"}, 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        check({name, "_lat1"}, 32'(m_valid), 32'd0);
        tick();
        @(negedge clk);
        check({name, "_lat2"}, 32'(m_valid), 32'd1);
        check({name, "_data"}, m_data, exp);
        tick();
    endtask

    logic [31:0] cur;
    logic [31:0] held;
    int          sent;
    int          acc;
    int          cyc;

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        s_mode  = 1'b0;
        m_ready = 1'b1;

        repeat (3) begin
            @(negedge clk);
            check("rst_s_ready", 32'(s_ready), 32'd0);
        end
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_m_valid", 32'(m_valid), 32'd0);
        tick();

        // Hand-computed literals: white/black, primaries, and red in packed-gray mode.
        run_single("wb_y8", {16'hFFFF, 16'h0000}, 1'b0, {16'h00FF, 16'h0000});
        run_single("wb_565", {16'hFFFF, 16'h0000}, 1'b1, {16'hFFFF, 16'h0000});
`ifdef GRAYSCALE_ROUND_EN
        run_single("green_red", {16'h07E0, 16'hF800}, 1'b0, {16'h00B6, 16'h0036});
        run_single("red_blue", {16'hF800, 16'h001F}, 1'b0, {16'h0036, 16'h0013});
`else
        run_single("green_red", {16'h07E0, 16'hF800}, 1'b0, {16'h00B6, 16'h0035});
        run_single("red_blue", {16'hF800, 16'h001F}, 1'b0, {16'h0035, 16'h0012});
`endif
        run_single("red_565", {16'h0000, 16'hF800}, 1'b1, {16'h0000, 16'h31A6});

        // 16-beat burst at full rate.
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                s_valid = 1'b1;
                s_data  = $urandom;
                s_mode  = 1'($urandom % 2);
                s_last  = (i == 15);
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            @(negedge clk);
            if (i < 16) check("burst_s_ready", 32'(s_ready), 32'd1);
            check("burst_m_valid", 32'(m_valid), 32'(i >= 2));
            tick();
        end

        // Backpressure: m_ready low for 5 cycles, 8 beats offered back-to-back.
        cur  = $urandom;
        sent = 0;
        held = '0;
        for (int i = 0; i < 14; i++) begin
            m_ready = (i >= 5);
            if (sent < 8) begin
                s_valid = 1'b1;
                s_data  = cur;
                s_mode  = cur[3];
                s_last  = (sent == 7);
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            @(negedge clk);
            if (i < 5) check("bp_s_ready", 32'(s_ready), 32'(i < 2));
            if (i >= 2 && i < 5) check("bp_m_valid", 32'(m_valid), 32'd1);
            if (i == 2) held = m_data;
            if (i == 4) check("bp_stable", m_data, held);
            if (s_valid && s_ready) begin
                sent++;
                cur = $urandom;
            end
            tick();
        end
        check("bp_sent", 32'(sent), 32'd8);

        // Randomized traffic on both sides with mixed modes.
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            s_valid = ($urandom % 4) != 0;
            s_data  = $urandom;
            s_mode  = 1'($urandom % 2);
            s_last  = ($urandom % 8) == 0;
            m_ready = ($urandom % 3) != 0;
            @(negedge clk);
            if (s_valid && s_ready) acc++;
            cyc++;
            tick();
        end
        check("rand_accepted", 32'(acc), 32'd1000);
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (4) tick();
        check("drain_empty", 32'(sb_q.size()), 32'd0);

        // Reset with two beats in flight, then a fresh beat right after release.
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            s_mode  = 1'b0;
            @(negedge clk);
            check("mid_fill_s_ready", 32'(s_ready), 32'd1);
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_s_ready", 32'(s_ready), 32'd0);
        tick();
        rst     = 1'b0;
        m_ready = 1'b1;
        cur     = $urandom;
        s_valid = 1'b1;
        s_data  = cur;
        s_mode  = 1'b1;
        s_last  = 1'b1;
        @(negedge clk);
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_m_data", m_data, 32'd0);
        check("mid_rst_m_last", 32'(m_last), 32'd0);
        check("mid_rst_s_ready_rel", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        check("post_rst_lat1", 32'(m_valid), 32'd0);
        tick();
        @(negedge clk);
        check("post_rst_lat2", 32'(m_valid), 32'd1);
        check("post_rst_data", m_data, model_beat(cur, 1'b1));
        check("post_rst_last", 32'(m_last), 32'd1);
        tick();
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
